// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, waits for data SRAM read
// data on loads (raising a stall request while it is outstanding), aligns and
// extends load data, and drives the WB and ID forwarding buses.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | instruction in MEM is not a load, or is a bubble
// S_WAIT | load in MEM, read data not yet returned
// S_DONE | load data captured in rdata_r, held until the load leaves
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [81:0] ex_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
    input  logic        data_sram_rvalid,
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_id_bus,
    output logic        stallreq_for_mem
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } load_state_t;

    load_state_t state;
    logic [81:0] ex_to_mem_bus_r;
    logic [31:0] rdata_r;

    // Only the MEM and WB stall bits matter here.
    logic        unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    // Load detection on the incoming bus (decides the state on capture).
    logic        in_is_load;
    assign in_is_load = ex_to_mem_bus[43] && (ex_to_mem_bus[42:39] == 4'b0000);

    // Fields of the registered bus.
    logic [5:0]  mem_op;
    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we_r;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [1:0]  addr_off;

    assign mem_op     = ex_to_mem_bus_r[81:76];
    assign pc         = ex_to_mem_bus_r[75:44];
    assign sel_rf_res = ex_to_mem_bus_r[38];
    assign rf_we_r    = ex_to_mem_bus_r[37];
    assign rf_waddr   = ex_to_mem_bus_r[36:32];
    assign ex_result  = ex_to_mem_bus_r[31:0];
    assign addr_off   = ex_result[1:0];

    logic        unused_bus_bits;
    assign unused_bus_bits = ^ex_to_mem_bus_r[43:39];

    // Pipeline register and load FSM advance together; a bubble or reset
    // discards any read data arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
            state           <= S_IDLE;
            rdata_r         <= '0;
        end else if (stall[3] == STOP && stall[4] == NO_STOP) begin
            ex_to_mem_bus_r <= '0;
            state           <= S_IDLE;
        end else if (stall[3] == NO_STOP) begin
            ex_to_mem_bus_r <= ex_to_mem_bus;
            state           <= in_is_load ? S_WAIT : S_IDLE;
        end else if (state == S_WAIT && data_sram_rvalid) begin
            state   <= S_DONE;
            rdata_r <= data_sram_rdata;
        end
    end

    // Raw load word: captured copy once DONE, otherwise the live SRAM data
    // so a load completes in the cycle rvalid arrives.
    logic [31:0] raw;
    assign raw = (state == S_DONE) ? rdata_r : data_sram_rdata;

    // Byte/halfword select and extension; misaligned offsets are not trapped.
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        load_byte = raw[7:0];
        case (addr_off)
            2'd0: load_byte = raw[7:0];
            2'd1: load_byte = raw[15:8];
            2'd2: load_byte = raw[23:16];
            2'd3: load_byte = raw[31:24];
            default: load_byte = raw[7:0];
        endcase
        load_half = addr_off[1] ? raw[31:16] : raw[15:0];
        case (mem_op)
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h0, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0, load_half};
            OP_LW:   load_data = raw;
            default: load_data = raw;
        endcase
    end

    // Writeback suppressed while the load data is still outstanding.
    logic [31:0] rf_wdata;
    logic        rf_we;

    assign stallreq_for_mem = (state == S_WAIT) && !data_sram_rvalid;
    assign rf_we            = rf_we_r && !stallreq_for_mem;
    assign rf_wdata         = sel_rf_res ? load_data : ex_result;

    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of per-cycle expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [81:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;
    logic        stallreq_for_mem;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id_bus    (mem_to_id_bus),
        .stallreq_for_mem (stallreq_for_mem)
    );

    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [5:0] ST_HOLD   = 6'b011111;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;
    localparam logic [31:0] RAW      = 32'h80FF_7F01;

    typedef struct {
        string       tag;
        logic [69:0] wb;
        logic [69:0] mask;
        logic        stl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [81:0] mk_bus(input logic [5:0] op, input logic [31:0] pc,
                                           input logic en, input logic [3:0] wen,
                                           input logic sel, input logic we,
                                           input logic [4:0] wa, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    task automatic push(input string tag, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic stl, input logic full);
        exp_t e;
        e.tag  = tag;
        e.wb   = {pc, we, wa, wd};
        e.mask = full ? {70{1'b1}} : {32'hFFFF_FFFF, 1'b1, 5'h1F, 32'h0};
        e.stl  = stl;
        sb.push_back(e);
    endtask

    task automatic push_zero(input string tag);
        push(tag, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk();
        exp_t e;
        @(negedge clk);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed 0 entries expected 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert ((mem_to_wb_bus & e.mask) === (e.wb & e.mask)) else begin
                errors++;
                $error("FAIL %s wb observed %h expected %h", e.tag,
                       mem_to_wb_bus & e.mask, e.wb & e.mask);
            end
            checks++;
            assert ((mem_to_id_bus & e.mask[37:0]) === (e.wb[37:0] & e.mask[37:0])) else begin
                errors++;
                $error("FAIL %s id observed %h expected %h", e.tag,
                       mem_to_id_bus & e.mask[37:0], e.wb[37:0] & e.mask[37:0]);
            end
            checks++;
            assert (stallreq_for_mem === e.stl) else begin
                errors++;
                $error("FAIL %s stallreq observed %b expected %b", e.tag,
                       stallreq_for_mem, e.stl);
            end
        end
    endtask

    // Load whose read data returns in its first MEM cycle.
    task automatic load_fast(input logic [5:0] op, input logic [31:0] pc,
                             input logic [1:0] off, input logic [4:0] wa,
                             input logic [31:0] exp_data);
        ex_to_mem_bus = mk_bus(op, pc, 1'b1, 4'b0000, 1'b1, 1'b1, wa,
                               {30'h0000_0400, off});
        push($sformatf("load_op%b_off%0d", op, off), pc, 1'b1, wa, exp_data, 1'b0, 1'b1);
        cyc();
        ex_to_mem_bus    = '0;
        data_sram_rdata  = RAW;
        data_sram_rvalid = 1'b1;
        chk();
        data_sram_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with arbitrary inputs
        rst              = 1'b1;
        stall            = 6'b101010;
        ex_to_mem_bus    = mk_bus(OP_LW, 32'hBFC0_0000, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd9, 32'h44);
        data_sram_rdata  = 32'h5555_AAAA;
        data_sram_rvalid = 1'b1;
        push_zero("rst_c0");
        cyc(); chk();
        push_zero("rst_c1");
        cyc(); chk();

        // ALU pass-through
        rst              = 1'b0;
        stall            = 6'b000000;
        data_sram_rvalid = 1'b0;
        ex_to_mem_bus    = mk_bus(OP_ALU, 32'hBFC0_0100, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        push("addu", 32'hBFC0_0100, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
        cyc();
        ex_to_mem_bus = '0;
        chk();

        // Store: no stall, no writeback
        ex_to_mem_bus = mk_bus(OP_SW, 32'hBFC0_0104, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd7, 32'h0000_2004);
        push("sw", 32'hBFC0_0104, 1'b0, 5'd7, 32'h0000_2004, 1'b0, 1'b1);
        cyc();
        ex_to_mem_bus = '0;
        chk();

        // Load extension on 0x80FF_7F01
        load_fast(OP_LB,  32'hBFC0_0200, 2'd1, 5'd1, 32'h0000_007F);
        load_fast(OP_LB,  32'hBFC0_0204, 2'd2, 5'd2, 32'hFFFF_FFFF);
        load_fast(OP_LB,  32'hBFC0_0208, 2'd0, 5'd3, 32'h0000_0001);
        load_fast(OP_LBU, 32'hBFC0_020C, 2'd3, 5'd4, 32'h0000_0080);
        load_fast(OP_LH,  32'hBFC0_0210, 2'd2, 5'd5, 32'hFFFF_80FF);
        load_fast(OP_LH,  32'hBFC0_0214, 2'd1, 5'd6, 32'h0000_7F01);
        load_fast(OP_LHU, 32'hBFC0_0218, 2'd0, 5'd7, 32'h0000_7F01);
        load_fast(OP_LHU, 32'hBFC0_021C, 2'd3, 5'd8, 32'h0000_80FF);
        load_fast(OP_LW,  32'hBFC0_0220, 2'd0, 5'd9, 32'h80FF_7F01);
        load_fast(OP_LW,  32'hBFC0_0224, 2'd3, 5'd10, 32'h80FF_7F01);

        // Three-cycle latency LW: two stall cycles
        ex_to_mem_bus = mk_bus(OP_LW, 32'hBFC0_0300, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd12, 32'h0000_1008);
        push("lat_c1", 32'hBFC0_0300, 1'b0, 5'd12, 32'h0, 1'b1, 1'b0);
        cyc();
        ex_to_mem_bus    = '0;
        stall            = ST_HOLD;
        data_sram_rvalid = 1'b0;
        data_sram_rdata  = 32'h1111_2222;
        chk();
        push("lat_c2", 32'hBFC0_0300, 1'b0, 5'd12, 32'h0, 1'b1, 1'b0);
        cyc(); chk();
        push("lat_c3", 32'hBFC0_0300, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 1'b1);
        cyc();
        stall            = 6'b000000;
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 32'hCAFE_0001;
        chk();
        data_sram_rvalid = 1'b0;
        push_zero("lat_after");
        cyc(); chk();

        // Held result under downstream stall; spurious rvalid in DONE
        ex_to_mem_bus = mk_bus(OP_LW, 32'hBFC0_0400, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd20, 32'h0000_1010);
        push("held_c0", 32'hBFC0_0400, 1'b1, 5'd20, 32'h1357_9BDF, 1'b0, 1'b1);
        cyc();
        ex_to_mem_bus    = '0;
        stall            = ST_HOLD;
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 32'h1357_9BDF;
        chk();
        push("held_c1", 32'hBFC0_0400, 1'b1, 5'd20, 32'h1357_9BDF, 1'b0, 1'b1);
        cyc();
        data_sram_rdata  = 32'hDEAD_BEEF;
        data_sram_rvalid = 1'b1;
        chk();
        push("held_c2", 32'hBFC0_0400, 1'b1, 5'd20, 32'h1357_9BDF, 1'b0, 1'b1);
        cyc();
        stall            = 6'b000000;
        data_sram_rvalid = 1'b0;
        chk();
        push_zero("held_after");
        cyc(); chk();

        // Bubble zeroes the bus and drops the upstream instruction
        ex_to_mem_bus = mk_bus(OP_ALU, 32'hBFC0_0500, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd17, 32'hA5A5_0F0F);
        push("bub_alu", 32'hBFC0_0500, 1'b1, 5'd17, 32'hA5A5_0F0F, 1'b0, 1'b1);
        cyc();
        ex_to_mem_bus = mk_bus(OP_ALU, 32'hBFC0_0504, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd18, 32'h0000_0777);
        stall         = ST_BUBBLE;
        chk();
        push_zero("bubble");
        cyc();
        stall         = 6'b000000;
        ex_to_mem_bus = '0;
        chk();

        // Bubble on the same edge as rvalid in WAIT
        ex_to_mem_bus = mk_bus(OP_LW, 32'hBFC0_0600, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd21, 32'h0000_1020);
        push("bub_load", 32'hBFC0_0600, 1'b1, 5'd21, 32'h0BAD_F00D, 1'b0, 1'b1);
        cyc();
        ex_to_mem_bus    = '0;
        stall            = ST_BUBBLE;
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = 32'h0BAD_F00D;
        chk();
        push_zero("bub_discard");
        cyc();
        stall            = 6'b000000;
        data_sram_rvalid = 1'b0;
        chk();

        // Reset while waiting aborts the load
        ex_to_mem_bus = mk_bus(OP_LW, 32'hBFC0_0700, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd3, 32'h0000_1030);
        push("abort_wait", 32'hBFC0_0700, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0);
        cyc();
        ex_to_mem_bus    = '0;
        data_sram_rvalid = 1'b0;
        chk();
        rst = 1'b1;
        push_zero("abort_rst");
        cyc();
        rst = 1'b0;
        chk();
        push_zero("post_abort");
        cyc(); chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
